maze_port_arbiter: RTL and testbench
====================================

// Module: maze_port_arbiter
// PURPOSE
//  Shares the single synchronous maze memory port (row/col/maze_oe/maze_we/maze_in) among NUM_REQ
//  solver agents. Round-robin arbitration, one access per cycle, pipelined read return.
//  Supports a short lock so one agent can do an atomic read-then-mark of the same cell.
//  Tracks per-agent completion and raises all_done. Sits between the solver FSMs and the maze RAM.
// PARAMETERS
//  NUM_REQ     2   number of requesting agents (2..8)
//  maze_width  6   row/col index width
//  LOCK_TO     15  idle cycles after which a held lock is force-released
// PORTS
//  clk        in   1                   single clock, all logic on posedge
//  rst_n      in   1                   asynchronous, active-low reset
//  req        in   NUM_REQ             per-agent request valid; held until its gnt bit is seen
//  req_we     in   NUM_REQ             1 = write/mark cell, 0 = read cell
//  req_lock   in   NUM_REQ             1 = keep ownership after this access
//  req_row    in   NUM_REQ*maze_width  packed row index, agent i at [i*W +: W]
//  req_col    in   NUM_REQ*maze_width  packed column index, same packing
//  agent_done in   NUM_REQ             agent i finished; sticky-retires it from arbitration
//  gnt        out  NUM_REQ             combinational ready, one-hot or zero; transfer = req[i]&gnt[i] at posedge
//  rvalid     out  NUM_REQ             one-cycle pulse, read data for agent i is valid
//  rdata      out  1                   registered copy of maze_in for the read named by rvalid
//  row, col   out  maze_width          registered memory address
//  maze_oe    out  1                   registered read enable
//  maze_we    out  1                   registered write enable
//  all_done   out  1                   registered; high once every agent has retired, sticky
// BEHAVIOUR
//  Reset: row=col=0, maze_oe=maze_we=0, rvalid=0, rdata=0, all_done=0, retired=0, lock cleared,
//   rr pointer=NUM_REQ-1 so agent 0 has first priority. In-flight reads are discarded; no rvalid after release.
//  Arbitration (comb): eligible = req & ~retired & ~agent_done.
//   Lock held: gnt = owner bit if eligible, else 0.
//   Lock free: first eligible index scanning ptr+1..NUM_REQ-1, 0..ptr with wrap.
//  Transfer at edge E0: row/col <= agent address, maze_we <= req_we, maze_oe <= ~req_we, ptr <= winner.
//   No transfer: maze_oe=maze_we=0 next cycle; row/col hold their last value.
//  Read pipeline: port active in cycle after E0, maze_in valid the cycle after that.
//   rdata/rvalid[i] registered at E2, so visible 3 edges after the handshake (E0+3 cycles visible).
//   The 2-deep tag pipe carries {owner, is_read}. Writes produce no rvalid. Throughput is one access per cycle.
//  Lock:
//   - Transfer with req_lock=1 sets owner=winner and clears idle_cnt.
//   - Transfer by the owner with req_lock=0 releases the lock at that edge.
//   - Each cycle the owner does not transfer, idle_cnt++. At idle_cnt==LOCK_TO-1 the lock releases,
//     so another agent can transfer exactly LOCK_TO cycles after the owner's last transfer.
//   - Owner retiring releases the lock immediately.
//  Retire: agent_done[i] sampled each edge; retired[i] sticky. gnt[i] is 0 in the cycle agent_done[i] is high.
//   all_done <= &(retired | agent_done).
//  Simultaneous: only one gnt bit ever. A retire and a lock release in the same cycle are both applied.
//   Pending reads of a retired agent still return rvalid.
// STRUCTURE
//  maze_defs.vh (shared include): maze_width default, ACC_READ/ACC_WRITE encodings, agent-id width macro
//   $clog2(NUM_REQ). Reused by the solver FSMs.
//  Sub-module rr_pick: comb round-robin priority picker (eligible, ptr -> one-hot, index, any).
//  Top holds the port registers, tag pipe, lock owner/counter and retire mask.
// TESTING
//  1 Single read:
//    stimulus: agent0 reads row=5 col=7, model cell=1.
//    response: gnt[0] same cycle; next cycle row=5 col=7 maze_oe=1; rvalid[0]=1 rdata=1 three cycles after the handshake.
//  2 Fairness:
//    stimulus: agents 0,1 request reads every cycle from reset.
//    response: grants 0,1,0,1...; 20 grants give 10 each; rvalid order matches the grant order.
//  3 Atomic mark:
//    stimulus: agent0 reads (lock=1) then writes (5,7) with lock=0 while agent1 requests.
//    response: gnt[1]=0 through both agent0 accesses; maze_we=1 at (5,7); agent1 granted the next cycle.
//  4 Lock timeout:
//    stimulus: agent0 transfers with lock=1 then drops req; agent1 requests.
//    response: agent1's first transfer occurs exactly 15 cycles after agent0's.
//  5 Retire:
//    stimulus: agent_done[0]=1 while req[0]=1.
//    response: gnt[0] never again. Then agent_done[1]=1 -> all_done=1 next cycle and stays high.
//  6 Reset mid-read:
//    stimulus: rst_n=0 one cycle after a read handshake.
//    response: all outputs 0 immediately; no rvalid after release; agent0 wins the first grant.

Source files
------------

// File: rtl/maze_port_arbiter_pkg.sv
// Shared definitions for the maze port arbiter and the solver agents that talk to it:
// default index width, access-type encoding and agent-id width helper.
package maze_port_arbiter_pkg;

  localparam int MAZE_W_DEFAULT = 6;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_e;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maze_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible agent after ptr, with wrap.
module maze_port_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && eligible[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing the single synchronous maze RAM port among NUM_REQ solver agents,
// with a short access lock for atomic read-then-mark, pipelined read return and retirement tracking.
module maze_port_arbiter
  import maze_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int maze_width = MAZE_W_DEFAULT,
  parameter int LOCK_TO    = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*maze_width-1:0] req_row,
  input  logic [NUM_REQ*maze_width-1:0] req_col,
  input  logic [NUM_REQ-1:0]            agent_done,
  input  logic                          maze_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic                          rdata,
  output logic [maze_width-1:0]         row,
  output logic [maze_width-1:0]         col,
  output logic                          maze_oe,
  output logic                          maze_we,
  output logic                          all_done
);

  localparam int IW = id_w(NUM_REQ);
  localparam int CW = $clog2(LOCK_TO);

  logic [maze_width-1:0] row_arr [NUM_REQ];
  logic [maze_width-1:0] col_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign row_arr[g] = req_row[g*maze_width +: maze_width];
    assign col_arr[g] = req_col[g*maze_width +: maze_width];
  end

  logic [NUM_REQ-1:0]    retired_q, retired_d, eligible, pick_oh;
  logic [IW-1:0]         ptr_q, ptr_d, owner_q, owner_d, pick_idx, win_idx;
  logic [IW-1:0]         tag1_id_q, tag1_id_d, tag2_id_q, tag2_id_d;
  logic                  tag1_vld_q, tag1_vld_d, tag2_vld_q, tag2_vld_d;
  logic                  pick_any, lock_q, lock_d, lock_eff, transfer;
  logic [CW-1:0]         idle_q, idle_d;
  logic [maze_width-1:0] row_q, row_d, col_q, col_d;
  logic                  oe_q, oe_d, we_q, we_d, rdata_q, rdata_d, all_done_q, all_done_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  acc_e                  acc;

  assign eligible = req & ~retired_q & ~agent_done;

  maze_port_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .onehot   (pick_oh),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // A retiring owner frees the port in the same cycle so others are not stalled.
  assign lock_eff = lock_q & ~agent_done[owner_q] & ~retired_q[owner_q];

  always_comb begin
    gnt      = '0;
    win_idx  = pick_idx;
    transfer = pick_any;
    if (lock_eff) begin
      win_idx      = owner_q;
      gnt[owner_q] = eligible[owner_q];
      transfer     = eligible[owner_q];
    end else begin
      gnt = pick_oh;
    end
  end

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    oe_d       = 1'b0;
    we_d       = 1'b0;
    ptr_d      = ptr_q;
    acc        = acc_e'(req_we[win_idx]);
    lock_d     = lock_eff;
    owner_d    = owner_q;
    idle_d     = idle_q;
    tag1_vld_d = 1'b0;
    tag1_id_d  = win_idx;
    if (transfer) begin
      row_d      = row_arr[win_idx];
      col_d      = col_arr[win_idx];
      we_d       = (acc == ACC_WRITE);
      oe_d       = (acc == ACC_READ);
      ptr_d      = win_idx;
      tag1_vld_d = (acc == ACC_READ);
      idle_d     = '0;
      if (req_lock[win_idx]) begin
        lock_d  = 1'b1;
        owner_d = win_idx;
      end else begin
        lock_d  = 1'b0;
      end
    end else if (lock_eff) begin
      // Release as the counter reaches LOCK_TO-1, so a rival transfers LOCK_TO cycles after the owner.
      if (idle_q == CW'(LOCK_TO - 2)) begin
        lock_d = 1'b0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + CW'(1);
      end
    end
    // Tag stage 2 lines up with maze_in; rdata/rvalid are captured from it.
    tag2_vld_d = tag1_vld_q;
    tag2_id_d  = tag1_id_q;
    rvalid_d   = tag2_vld_q ? (NUM_REQ'(1) << tag2_id_q) : '0;
    rdata_d    = tag2_vld_q ? maze_in : rdata_q;
    retired_d  = retired_q | agent_done;
    all_done_d = all_done_q | (&(retired_q | agent_done));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      col_q      <= '0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      ptr_q      <= IW'(NUM_REQ - 1);
      lock_q     <= 1'b0;
      owner_q    <= '0;
      idle_q     <= '0;
      tag1_vld_q <= 1'b0;
      tag1_id_q  <= '0;
      tag2_vld_q <= 1'b0;
      tag2_id_q  <= '0;
      rvalid_q   <= '0;
      rdata_q    <= 1'b0;
      retired_q  <= '0;
      all_done_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      idle_q     <= idle_d;
      tag1_vld_q <= tag1_vld_d;
      tag1_id_q  <= tag1_id_d;
      tag2_vld_q <= tag2_vld_d;
      tag2_id_q  <= tag2_id_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      retired_q  <= retired_d;
      all_done_q <= all_done_d;
    end
  end

  assign row      = row_q;
  assign col      = col_q;
  assign maze_oe  = oe_q;
  assign maze_we  = we_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign all_done = all_done_q;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed bench for maze_port_arbiter with two agents and a behavioural synchronous maze RAM.
module tb_maze_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, req_we, req_lock, agent_done, gnt, rvalid;
  logic [5:0] r0, c0, r1, c1, row, col;
  logic       maze_in, rdata, maze_oe, maze_we, all_done;
  logic       mem [0:63][0:63];
  logic       mem_out;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  maze_port_arbiter #(.NUM_REQ(2), .maze_width(6), .LOCK_TO(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_row    ({r1, r0}),
    .req_col    ({c1, c0}),
    .agent_done (agent_done),
    .maze_in    (maze_in),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .row        (row),
    .col        (col),
    .maze_oe    (maze_oe),
    .maze_we    (maze_we),
    .all_done   (all_done)
  );

  always @(posedge clk) begin
    if (maze_we) mem[row][col] <= 1'b1;
    if (maze_oe) mem_out <= mem[row][col];
  end
  assign maze_in = mem_out;

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; req_we = '0; req_lock = '0; agent_done = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if ({row, col} !== 12'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 000", {row, col}); end
    n_cmp++; if ({maze_oe, maze_we} !== 2'b00) begin n_fail++; $display("FAIL reset_en: got %b want 00", {maze_oe, maze_we}); end
    n_cmp++; if ({rvalid, rdata, all_done} !== 4'b0000) begin n_fail++; $display("FAIL reset_out: got %b want 0000", {rvalid, rdata, all_done}); end
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_idle: got %b want 00", gnt); end
    req = 2'b11; #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL reset_first_prio: got %b want 01", gnt); end
    req = 2'b00;
  endtask

  task automatic test_single_read();
    apply_reset();
    r0 = 6'd5; c0 = 6'd7; req_we = 2'b00; req = 2'b01; #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b want 01", gnt); end
    @(posedge clk); #1; req = 2'b00;
    n_cmp++; if ({row, col, maze_oe, maze_we} !== {6'd5, 6'd7, 2'b10}) begin n_fail++; $display("FAIL read_port: got %0d/%0d oe%b we%b want 5/7 oe1 we0", row, col, maze_oe, maze_we); end
    @(posedge clk); #1;
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL read_early: got %b want 00", rvalid); end
    @(posedge clk); #1;
    n_cmp++; if ({rvalid, rdata} !== 3'b011) begin n_fail++; $display("FAIL read_return: got rvalid %b rdata %b want 01 1", rvalid, rdata); end
    @(posedge clk); #1;
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL read_pulse: got %b want 00", rvalid); end
  endtask

  task automatic test_fairness();
    int q[$];
    int nrv, g0, g1, e;
    logic [1:0] exp_g;
    apply_reset();
    r0 = 6'd1; c0 = 6'd1; r1 = 6'd2; c1 = 6'd2; req_we = 2'b00; req_lock = 2'b00;
    nrv = 0; g0 = 0; g1 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      req = (i < 20) ? 2'b11 : 2'b00;
      #1;
      if (rvalid !== 2'b00) begin
        nrv++;
        e = (q.size() > 0) ? q.pop_front() : -1;
        n_cmp++;
        if (e < 0 || rvalid !== (2'b01 << e) || rdata !== (e == 1)) begin
          n_fail++; $display("FAIL fair_rvalid: got %b rdata %b want agent %0d", rvalid, rdata, e);
        end
      end
      if (i < 20) begin
        exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt%0d: got %b want %b", i, gnt, exp_g); end
        if (gnt[0]) g0++;
        if (gnt[1]) g1++;
        q.push_back(i % 2);
      end
    end
    n_cmp++; if (g0 != 10 || g1 != 10) begin n_fail++; $display("FAIL fair_count: got %0d/%0d want 10/10", g0, g1); end
    n_cmp++; if (nrv != 20) begin n_fail++; $display("FAIL fair_rvalid_count: got %0d want 20", nrv); end
  endtask

  task automatic test_atomic_mark();
    apply_reset();
    r0 = 6'd5; c0 = 6'd7; r1 = 6'd3; c1 = 6'd3;
    req = 2'b11; req_we = 2'b00; req_lock = 2'b01; #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL atomic_read_gnt: got %b want 01", gnt); end
    @(negedge clk);
    req_we = 2'b01; req_lock = 2'b00; #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL atomic_locked_gnt: got %b want 01", gnt); end
    @(posedge clk); #1;
    n_cmp++; if ({row, col, maze_we, maze_oe} !== {6'd5, 6'd7, 2'b10}) begin n_fail++; $display("FAIL atomic_mark: got %0d/%0d we%b oe%b want 5/7 we1 oe0", row, col, maze_we, maze_oe); end
    @(negedge clk);
    req = 2'b10; req_we = 2'b00; #1;
    n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL atomic_release: got %b want 10", gnt); end
    @(negedge clk); req = 2'b00;
  endtask

  task automatic test_lock_timeout();
    int first;
    logic [1:0] g14;
    apply_reset();
    r0 = 6'd4; c0 = 6'd4; r1 = 6'd6; c1 = 6'd6;
    req = 2'b11; req_we = 2'b00; req_lock = 2'b01; #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lock_first_gnt: got %b want 01", gnt); end
    first = 0; g14 = 2'bxx;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin req = 2'b10; req_lock = 2'b00; end
      #1;
      if (k == 14) g14 = gnt;
      if (gnt[1] && first == 0) first = k;
    end
    req = 2'b00;
    n_cmp++; if (g14 !== 2'b00) begin n_fail++; $display("FAIL lock_hold14: got %b want 00", g14); end
    n_cmp++; if (first != 15) begin n_fail++; $display("FAIL lock_timeout: got %0d want 15 cycles", first); end
  endtask

  task automatic test_retire();
    apply_reset();
    req = 2'b01; agent_done = 2'b01; #1;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL retire_same_cycle: got %b want 00", gnt); end
    @(negedge clk); agent_done = 2'b00; #1;
    n_cmp++; if ({gnt, all_done} !== 3'b000) begin n_fail++; $display("FAIL retire_sticky: got %b want 000", {gnt, all_done}); end
    @(negedge clk); req = 2'b11; #1;
    n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL retire_other: got %b want 10", gnt); end
    @(negedge clk); agent_done = 2'b10; #1;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL retire_both: got %b want 00", gnt); end
    @(posedge clk); #1;
    n_cmp++; if (all_done !== 1'b1) begin n_fail++; $display("FAIL all_done_set: got %b want 1", all_done); end
    @(negedge clk); agent_done = 2'b00; req = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++; if (all_done !== 1'b1) begin n_fail++; $display("FAIL all_done_sticky: got %b want 1", all_done); end
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    apply_reset();
    r0 = 6'd5; c0 = 6'd7; req_we = 2'b00; req = 2'b01;
    @(posedge clk);
    @(negedge clk); req = 2'b00; rst_n = 1'b0; #1;
    n_cmp++; if ({row, col, maze_oe, maze_we, rvalid, rdata} !== 17'd0) begin n_fail++; $display("FAIL midreset_out: got %h want 0", {row, col, maze_oe, maze_we, rvalid, rdata}); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); #1; if (rvalid !== 2'b00) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_rvalid: got %b want 0", seen); end
    req = 2'b11; #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL midreset_prio: got %b want 01", gnt); end
    req = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        mem[i][j] = 1'b0;
    mem[5][7] = 1'b1;
    mem[2][2] = 1'b1;
    mem_out = 1'b0;
    r0 = '0; c0 = '0; r1 = '0; c1 = '0;
    test_reset();
    test_single_read();
    test_fairness();
    test_atomic_mark();
    test_lock_timeout();
    test_retire();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
